// File: rtl/ftw_meter_if.sv
// Measurement bus of ftw_meter: the observed signal and enable in, the recovered word out.
// The meter owns the outputs and there is no backpressure: valid is a bare one-cycle pulse.
interface ftw_meter_if #(
  parameter int FTW_W = 16
);
  logic             enable;
  logic             sig_in;
  logic [FTW_W-1:0] ftw_out;
  logic             valid;
  logic             overflow;

  modport master (output enable, sig_in, input ftw_out, valid, overflow);
  modport slave  (input enable, sig_in, output ftw_out, valid, overflow);
endinterface

// File: rtl/ftw_meter.sv
// Recovers FTW = floor(PERIODS*2^FTW_W/cycles) from a clk-synchronous square wave; valid NUM_W+2
// cycles after the closing edge. There is no backpressure: each result is pulsed once on valid and then held.
module ftw_meter #(
  parameter int FTW_W   = 16,
  parameter int PERIODS = 16,
  parameter int CNT_W   = 24
) (
  input  logic        clk,
  input  logic        reset,
  ftw_meter_if.slave  bus
);

  localparam int NUM_W = FTW_W + $clog2(PERIODS) + 1;
  localparam int PER_W = (PERIODS > 1) ? $clog2(PERIODS) : 1;
  localparam int BIT_W = $clog2(NUM_W + 1);

  localparam logic [NUM_W-1:0] NUMER    = NUM_W'(PERIODS) << FTW_W;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIODS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_W - 1);
  localparam logic [CNT_W-1:0] CYC_MAX  = '1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_MEAS = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             sig_q;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [CNT_W:0]   div_q, div_d;
  logic [CNT_W:0]   rem_q, rem_d;
  logic [NUM_W-1:0] dq_q, dq_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [FTW_W-1:0] ftw_q, ftw_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic             rise;
  logic [CNT_W+1:0] rem_sh;
  logic [CNT_W+1:0] rem_sub;

  assign rise = bus.sig_in & ~sig_q;

  assign bus.ftw_out  = ftw_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = ovf_q;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    per_d      = per_q;
    div_d      = div_q;
    rem_d      = rem_q;
    dq_d       = dq_q;
    bit_d      = bit_q;
    ovf_pend_d = ovf_pend_q;
    ftw_d      = ftw_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    rem_sh     = '0;
    rem_sub    = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.enable) state_d = S_ARM;
      end

      S_ARM: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
        end else if (rise) begin
          cyc_d   = '0;
          per_d   = '0;
          state_d = S_MEAS;
        end
      end

      S_MEAS: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
        end else begin
          cyc_d = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + CNT_W'(1);
          // Closing edge wins over a simultaneous counter timeout.
          if (rise && per_q == PER_LAST) begin
            div_d      = {1'b0, cyc_q} + (CNT_W + 1)'(1);
            dq_d       = NUMER;
            rem_d      = '0;
            bit_d      = '0;
            ovf_pend_d = 1'b0;
            state_d    = S_DIV;
          end else if (cyc_q == CYC_MAX) begin
            ovf_pend_d = 1'b1;
            state_d    = S_DONE;
          end else if (rise) begin
            per_d = per_q + PER_W'(1);
          end
        end
      end

      S_DIV: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
        end else begin
          // dq holds unconsumed numerator bits above the quotient bits shifted in so far.
          rem_sh  = {rem_q, dq_q[NUM_W-1]};
          rem_sub = rem_sh - {1'b0, div_q};
          if (rem_sh >= {1'b0, div_q}) begin
            rem_d = rem_sub[CNT_W:0];
            dq_d  = {dq_q[NUM_W-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[CNT_W:0];
            dq_d  = {dq_q[NUM_W-2:0], 1'b0};
          end
          bit_d = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) state_d = S_DONE;
        end
      end

      S_DONE: begin
        valid_d = 1'b1;
        if (ovf_pend_q) begin
          ftw_d = '0;
          ovf_d = 1'b1;
        end else begin
          ftw_d = (|dq_q[NUM_W-1:FTW_W]) ? '1 : dq_q[FTW_W-1:0];
          ovf_d = 1'b0;
        end
        state_d = bus.enable ? S_ARM : S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sig_q      <= 1'b0;
      cyc_q      <= '0;
      per_q      <= '0;
      div_q      <= '0;
      rem_q      <= '0;
      dq_q       <= '0;
      bit_q      <= '0;
      ovf_pend_q <= 1'b0;
      ftw_q      <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sig_q      <= bus.sig_in;
      cyc_q      <= cyc_d;
      per_q      <= per_d;
      div_q      <= div_d;
      rem_q      <= rem_d;
      dq_q       <= dq_d;
      bit_q      <= bit_d;
      ovf_pend_q <= ovf_pend_d;
      ftw_q      <= ftw_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_ftw_meter.sv
// Bench for ftw_meter: accumulator/toggle/pulse stimulus, results checked against an edge-timestamp model.
module tb_ftw_meter;
  localparam int FTW_W   = 16;
  localparam int PERIODS = 16;
  localparam int CNT_W   = 12;
  localparam int NUM_W   = FTW_W + $clog2(PERIODS) + 1;
  localparam int LAT     = NUM_W + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ftw_meter_if #(.FTW_W(FTW_W)) bus();
  ftw_meter #(.FTW_W(FTW_W), .PERIODS(PERIODS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int tests_run = 0;
  int fails = 0;

  // Stimulus: 0 low, 1 phase accumulator MSB, 2 toggle, 3 single pulses on request
  int          mode = 0;
  logic [15:0] acc_ftw = 16'd0;
  logic [15:0] phase = 16'd0;
  int          pulse_req = 0;
  int          pulse_done = 0;

  int   cyc_n = 0;
  logic prev_s = 1'b0;
  logic rst_at_edge = 1'b0;
  int   edges[$];
  int   ev_t[$];
  int   ev_f[$];
  int   ev_o[$];
  int   rd_idx = 0;
  int   dbl_cnt = 0;
  int   viol_cnt = 0;
  logic vld_prev = 1'b0;
  logic [15:0] ftw_prev = 16'd0;
  logic ovf_prev = 1'b0;

  initial begin
    bus.sig_in = 1'b0;
    bus.enable = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        1: begin phase = phase + acc_ftw; bus.sig_in = phase[15]; end
        2: bus.sig_in = ~bus.sig_in;
        3: begin bus.sig_in = (pulse_req != pulse_done); pulse_done = pulse_req; end
        default: bus.sig_in = 1'b0;
      endcase
    end
  end

  // Rising edges as the DUT sees them, stamped with the cycle index that ends at this posedge
  initial forever begin
    @(posedge clk);
    rst_at_edge = reset;
    if (reset) prev_s = 1'b0;
    else begin
      if (bus.sig_in && !prev_s) edges.push_back(cyc_n);
      prev_s = bus.sig_in;
    end
    cyc_n++;
  end

  initial forever begin
    @(negedge clk);
    if (bus.valid === 1'b1) begin
      ev_t.push_back(cyc_n);
      ev_f.push_back(int'(bus.ftw_out));
      ev_o.push_back(int'(bus.overflow));
      if (vld_prev) dbl_cnt++;
    end else if (!rst_at_edge && (bus.ftw_out !== ftw_prev || bus.overflow !== ovf_prev)) begin
      viol_cnt++;
    end
    vld_prev = bus.valid;
    ftw_prev = bus.ftw_out;
    ovf_prev = bus.overflow;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int t, output int f, output int o);
    int n = 0;
    while (rd_idx >= ev_t.size() && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (rd_idx < ev_t.size());
    t = 0; f = -1; o = -1;
    if (ok) begin
      t = ev_t[rd_idx]; f = ev_f[rd_idx]; o = ev_o[rd_idx];
      rd_idx++;
    end
    cycles(1);
  endtask

  // Expected word from the 16 periods closed by the edge LAT cycles before the pulse
  task automatic model(input int v, output bit found, output int exp);
    int cyc;
    found = 1'b0;
    exp = -1;
    for (int j = edges.size() - 1; j >= PERIODS; j--) begin
      if (edges[j] == v - LAT) begin
        cyc = edges[j] - edges[j - PERIODS];
        exp = (PERIODS * 65536) / cyc;
        if (exp > 65535) exp = 65535;
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_sig_high();
    int n = 0;
    while (bus.sig_in !== 1'b1 && n < 200) begin cycles(1); n++; end
  endtask

  task automatic restart(input int m, input logic [15:0] f);
    bus.enable = 1'b0;
    mode = m;
    acc_ftw = f;
    cycles(4);
    rd_idx = ev_t.size();
    bus.enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycles(3);
    tests_run++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
    tests_run++; if (bus.ftw_out !== 16'd0) begin fails++; $display("FAIL reset_ftw got %0d exp 0", bus.ftw_out); end
    tests_run++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", bus.overflow); end
    reset = 1'b0;
    cycles(2);
  endtask

  task automatic test_basic();
    bit ok, fnd; int t, f, o, exp;
    restart(1, 16'd4096);
    for (int k = 0; k < 2; k++) begin
      wait_valid(2000, ok, t, f, o);
      model(t, fnd, exp);
      tests_run++; if (!ok) begin fails++; $display("FAIL basic_timeout got none exp valid"); end
      tests_run++; if (!fnd) begin fails++; $display("FAIL basic_latency valid at %0d, no edge at %0d", t, t - LAT); end
      tests_run++; if (f !== 4096) begin fails++; $display("FAIL basic_ftw got %0d exp 4096", f); end
      tests_run++; if (f !== exp) begin fails++; $display("FAIL basic_model got %0d exp %0d", f, exp); end
      tests_run++; if (o !== 0) begin fails++; $display("FAIL basic_ovf got %0d exp 0", o); end
    end
  endtask

  task automatic test_toggle();
    bit ok, fnd; int t, f, o, exp;
    restart(2, 16'd0);
    wait_valid(2000, ok, t, f, o);
    model(t, fnd, exp);
    tests_run++; if (!ok || !fnd) begin fails++; $display("FAIL toggle_timing got ok=%0d edge=%0d exp 1 1", ok, fnd); end
    tests_run++; if (f !== 32768) begin fails++; $display("FAIL toggle_ftw got %0d exp 32768", f); end
    tests_run++; if (o !== 0) begin fails++; $display("FAIL toggle_ovf got %0d exp 0", o); end
  endtask

  task automatic test_ftw1000();
    bit ok, fnd; int t, f, o, exp;
    restart(1, 16'd1000);
    wait_valid(3000, ok, t, f, o);
    model(t, fnd, exp);
    tests_run++; if (!ok || !fnd) begin fails++; $display("FAIL f1000_timing got ok=%0d edge=%0d exp 1 1", ok, fnd); end
    tests_run++; if (f < 999 || f > 1001) begin fails++; $display("FAIL f1000_range got %0d exp 999..1001", f); end
    tests_run++; if (f !== exp) begin fails++; $display("FAIL f1000_model got %0d exp %0d", f, exp); end
  endtask

  task automatic test_random();
    bit ok, fnd; int t, f, o, exp;
    logic [15:0] w;
    for (int k = 0; k < 4; k++) begin
      w = 16'($urandom_range(30000, 512));
      restart(1, w);
      wait_valid(5000, ok, t, f, o);
      model(t, fnd, exp);
      tests_run++; if (!ok || !fnd) begin fails++; $display("FAIL rand_timing ftw=%0d got ok=%0d edge=%0d exp 1 1", w, ok, fnd); end
      tests_run++; if (f !== exp || o !== 0) begin fails++; $display("FAIL rand_model ftw=%0d got %0d/%0d exp %0d/0", w, f, o, exp); end
    end
  endtask

  task automatic test_overflow();
    bit ok; int t, f, o, e;
    restart(3, 16'd0);
    cycles(4);
    pulse_req++;
    wait_valid(4500, ok, t, f, o);
    e = (edges.size() > 0) ? edges[edges.size() - 1] : 0;
    tests_run++; if (!ok) begin fails++; $display("FAIL ovf_timeout got none exp valid"); end
    tests_run++; if (o !== 1 || f !== 0) begin fails++; $display("FAIL ovf_result got ftw=%0d ovf=%0d exp 0 1", f, o); end
    tests_run++; if (t - e < 4097 || t - e > 4099) begin fails++; $display("FAIL ovf_delay got %0d exp 4097..4099", t - e); end
    restart(1, 16'd4096);
    wait_valid(2000, ok, t, f, o);
    tests_run++; if (!ok || o !== 0 || f !== 4096) begin fails++; $display("FAIL ovf_clear got ok=%0d ftw=%0d ovf=%0d exp 1 4096 0", ok, f, o); end
  endtask

  task automatic test_switch();
    bit ok, fnd; int t, f, o, exp, last_t;
    int res[4];
    restart(1, 16'd4096);
    wait_valid(2000, ok, t, f, o);
    tests_run++; if (!ok || f !== 4096) begin fails++; $display("FAIL sw_pre got %0d exp 4096", f); end
    last_t = t;
    acc_ftw = 16'd8192;
    for (int k = 0; k < 4; k++) begin
      wait_valid(2000, ok, t, f, o);
      model(t, fnd, exp);
      res[k] = f;
      tests_run++; if (!ok || !fnd || f !== exp) begin fails++; $display("FAIL sw_model[%0d] got %0d exp %0d", k, f, exp); end
      tests_run++; if (t - last_t < 2 || t - last_t > 400) begin fails++; $display("FAIL sw_spacing[%0d] got %0d exp 2..400", k, t - last_t); end
      last_t = t;
    end
    tests_run++; if (res[2] !== 8192 || res[3] !== 8192) begin fails++; $display("FAIL sw_settle got %0d %0d exp 8192", res[2], res[3]); end
  endtask

  task automatic test_enable_abort();
    bit ok; int t, f, o, base, n;
    restart(1, 16'd4096);
    wait_valid(2000, ok, t, f, o);
    tests_run++; if (!ok || f !== 4096) begin fails++; $display("FAIL abort_pre got %0d exp 4096", f); end
    bus.enable = 1'b0;
    cycles(3);
    wait_sig_high();
    base = edges.size();
    rd_idx = ev_t.size();
    bus.enable = 1'b1;
    n = 0;
    while (edges.size() < base + 6 && n < 300) begin cycles(1); n++; end
    bus.enable = 1'b0;
    cycles(400);
    tests_run++; if (rd_idx != ev_t.size()) begin fails++; $display("FAIL abort_novalid got %0d pulses exp 0", ev_t.size() - rd_idx); end
    tests_run++; if (bus.ftw_out !== 16'd4096 || bus.overflow !== 1'b0) begin fails++; $display("FAIL abort_hold got %0d/%b exp 4096/0", bus.ftw_out, bus.overflow); end
  endtask

  task automatic test_reset_divide();
    int base, n;
    bus.enable = 1'b0;
    mode = 1;
    acc_ftw = 16'd4096;
    cycles(3);
    wait_sig_high();
    base = edges.size();
    rd_idx = ev_t.size();
    bus.enable = 1'b1;
    n = 0;
    while (edges.size() < base + 17 && n < 600) begin cycles(1); n++; end
    cycles(5);
    reset = 1'b1;
    bus.enable = 1'b0;
    cycles(1);
    tests_run++; if (bus.ftw_out !== 16'd0 || bus.valid !== 1'b0 || bus.overflow !== 1'b0) begin fails++; $display("FAIL rstdiv_out got %0d/%b/%b exp 0/0/0", bus.ftw_out, bus.valid, bus.overflow); end
    reset = 1'b0;
    cycles(300);
    tests_run++; if (rd_idx != ev_t.size()) begin fails++; $display("FAIL rstdiv_novalid got %0d pulses exp 0", ev_t.size() - rd_idx); end
  endtask

  task automatic test_integrity();
    tests_run++; if (dbl_cnt != 0) begin fails++; $display("FAIL pulse_width got %0d long pulses exp 0", dbl_cnt); end
    tests_run++; if (viol_cnt != 0) begin fails++; $display("FAIL output_hold got %0d changes without valid exp 0", viol_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_ftw1000();
    test_random();
    test_overflow();
    test_switch();
    test_enable_abort();
    test_reset_divide();
    test_integrity();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
